// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: zigzag table, default widths, FSM states and
// run/value codes for the ZRL and EOB symbols.
package jpeg_pkg;

  localparam int COEF_W_DEF = 8;
  localparam int RUN_W_DEF  = 4;
  localparam int NCOEF      = 64;

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_e;

  // ZRL run is the all-ones run field; its value is zero.
  localparam int ZRL_VAL = 0;
  localparam int EOB_RUN = 0;
  localparam int EOB_VAL = 0;

  // zigzag index -> raster index (8*row+col)
  localparam logic [5:0] ZZ [NCOEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zigzag_lut.sv
// Combinational zigzag lookup.
// Ports: zz_idx_i (zigzag position) -> raster_idx_o (8*row+col).
module zigzag_lut
  import jpeg_pkg::*;
(
  input  logic [5:0] zz_idx_i,
  output logic [5:0] raster_idx_o
);

  assign raster_idx_o = ZZ[zz_idx_i];

endmodule

// File: rtl/zigzag_rle.sv
// Zigzag reorder + AC zero run-length encoder, one 8x8 block at a time.
// Ports: clk/reset (async high), in_block/in_valid/in_ready block input,
//   out_run/out_value/out_eob/out_last/out_valid/out_ready symbol stream.
// Define RLE_EOB_EN to end blocks with an EOB after the last nonzero.
module zigzag_rle
  import jpeg_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int RUN_W  = RUN_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCOEF*COEF_W-1:0] in_block,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [RUN_W-1:0]        out_run,
  output logic [COEF_W-1:0]       out_value,
  output logic                    out_eob,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int         BLK_W   = NCOEF * COEF_W;
  localparam logic [5:0] IDX_MAX = 6'd63;

  state_e              state_q, state_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic [5:0]          idx_q, idx_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [RUN_W-1:0]    orun_q, orun_d;
  logic [COEF_W-1:0]   oval_q, oval_d;
  logic                olast_q, olast_d;
  logic                ovld_q, ovld_d;
  logic [5:0]          ras;
  logic [COEF_W-1:0]   coef;
  logic [5:0]          lnz;
  logic                is_last;
  logic                adv;

  zigzag_lut u_lut (
    .zz_idx_i     (idx_q),
    .raster_idx_o (ras)
  );

  assign coef = blk_q[ras*COEF_W +: COEF_W];

`ifdef RLE_EOB_EN
  logic [5:0] lnz_q, lnz_d, nz_in;
  logic       eob_q, eob_d;
  logic       pend_q, pend_d;

  // highest zigzag position holding a nonzero coefficient
  always_comb begin
    nz_in = '0;
    for (int k = 0; k < NCOEF; k++)
      if (in_block[ZZ[k]*COEF_W +: COEF_W] != '0)
        nz_in = 6'(k);
  end

  assign lnz     = lnz_q;
  assign out_eob = eob_q;
`else
  assign lnz     = IDX_MAX;
  assign out_eob = 1'b0;
`endif

  assign is_last   = (idx_q == lnz);
  assign adv       = !ovld_q || out_ready;
  assign in_ready  = (state_q == S_IDLE);
  assign out_run   = orun_q;
  assign out_value = oval_q;
  assign out_last  = olast_q;
  assign out_valid = ovld_q;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    run_d   = run_q;
    orun_d  = orun_q;
    oval_d  = oval_q;
    olast_d = olast_q;
    ovld_d  = ovld_q;
`ifdef RLE_EOB_EN
    lnz_d   = lnz_q;
    eob_d   = eob_q;
    pend_d  = pend_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          blk_d   = in_block;
          idx_d   = '0;
          run_d   = '0;
          state_d = S_SCAN;
`ifdef RLE_EOB_EN
          lnz_d   = nz_in;
          pend_d  = 1'b0;
`endif
        end
      end
      S_SCAN: begin
        if (ovld_q && out_ready && olast_q) begin
          ovld_d  = 1'b0;
          olast_d = 1'b0;
          state_d = S_IDLE;
`ifdef RLE_EOB_EN
          eob_d   = 1'b0;
`endif
        end else if (adv) begin
          ovld_d = 1'b0;
`ifdef RLE_EOB_EN
          if (pend_q) begin
            ovld_d  = 1'b1;
            orun_d  = RUN_W'(EOB_RUN);
            oval_d  = COEF_W'(EOB_VAL);
            eob_d   = 1'b1;
            olast_d = 1'b1;
            pend_d  = 1'b0;
          end else
`endif
          begin
            if (idx_q == '0 || coef != '0 || is_last) begin
              ovld_d  = 1'b1;
              orun_d  = run_q;
              oval_d  = coef;
              run_d   = '0;
`ifdef RLE_EOB_EN
              eob_d   = 1'b0;
              // full block: last coefficient closes it, no EOB
              olast_d = is_last && (lnz == IDX_MAX);
              pend_d  = is_last && (lnz != IDX_MAX);
`else
              olast_d = is_last;
`endif
            end else if (run_q == {RUN_W{1'b1}}) begin
              ovld_d  = 1'b1;
              orun_d  = run_q;
              oval_d  = COEF_W'(ZRL_VAL);
              olast_d = 1'b0;
              run_d   = '0;
`ifdef RLE_EOB_EN
              eob_d   = 1'b0;
`endif
            end else begin
              run_d = run_q + RUN_W'(1);
            end
            if (!is_last)
              idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      idx_q   <= '0;
      run_q   <= '0;
      orun_q  <= '0;
      oval_q  <= '0;
      olast_q <= 1'b0;
      ovld_q  <= 1'b0;
`ifdef RLE_EOB_EN
      lnz_q   <= '0;
      eob_q   <= 1'b0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      orun_q  <= orun_d;
      oval_q  <= oval_d;
      olast_q <= olast_d;
      ovld_q  <= ovld_d;
`ifdef RLE_EOB_EN
      lnz_q   <= lnz_d;
      eob_q   <= eob_d;
      pend_q  <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_zigzag_rle.sv
// Self-checking bench for zigzag_rle: directed blocks, stalls, reset
// mid-block, held in_valid and random blocks against a list model.
`timescale 1ns/1ps
module tb_zigzag_rle;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] in_block = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   out_run;
  logic [7:0]   out_value;
  logic         out_eob;
  logic         out_last;
  logic         out_valid;
  logic         out_ready = 1'b0;

  zigzag_rle dut (
    .clk       (clk),
    .reset     (reset),
    .in_block  (in_block),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_run   (out_run),
    .out_value (out_value),
    .out_eob   (out_eob),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] run;
    logic [7:0] val;
    logic       eob;
    logic       last;
  } sym_t;

  int   total = 0;
  int   bad = 0;
  sym_t exp_q[$];
  int   zz[64];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // zigzag order derived by walking anti-diagonals
  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int i = hi; i >= lo; i--) begin
          zz[k] = 8 * i + (s - i);
          k++;
        end
      end else begin
        for (int i = lo; i <= hi; i++) begin
          zz[k] = 8 * i + (s - i);
          k++;
        end
      end
    end
  endtask

  task automatic push(input int run, input logic [7:0] val, input bit eob);
    sym_t s;
    s.run  = 4'(run);
    s.val  = val;
    s.eob  = eob;
    s.last = 1'b0;
    exp_q.push_back(s);
  endtask

  task automatic model(input logic [511:0] b);
    logic [7:0] v[64];
    int last;
    int run;
    exp_q.delete();
    for (int k = 0; k < 64; k++) v[k] = b[zz[k]*8 +: 8];
`ifdef RLE_EOB_EN
    last = 0;
    for (int k = 0; k < 64; k++) if (v[k] != 0) last = k;
`else
    last = 63;
`endif
    push(0, v[0], 0);
    run = 0;
    for (int k = 1; k <= last; k++) begin
      if (v[k] != 0 || k == last) begin
        push(run, v[k], 0);
        run = 0;
      end else if (run == 15) begin
        push(15, 8'h00, 0);
        run = 0;
      end else begin
        run++;
      end
    end
`ifdef RLE_EOB_EN
    if (last < 63) push(0, 8'h00, 1);
`endif
    exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  // rmode: 0 always ready, 1 alternating 1/0, 2 random
  task automatic run_block(input logic [511:0] b, input int rmode,
                           input bit hold, input int abort_n);
    int   got = 0;
    int   vc = 0;
    int   cyc = 0;
    bit   done = 0;
    bit   stall = 0;
    bit   r;
    sym_t prev;
    sym_t e;
    model(b);
    chk("in_ready_idle", 32'(in_ready), 1);
    in_block = b;
    in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_busy", 32'(in_ready), 0);
    chk("dc_not_yet", 32'(out_valid), 0);
    if (hold) in_block = {16{$urandom}};
    else in_valid = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_run", 32'(out_run), 32'(prev.run));
        chk("stall_val", 32'(out_value), 32'(prev.val));
        chk("stall_last", 32'(out_last), 32'(prev.last));
      end
      chk("no_new_block", 32'(in_ready), 0);
      case (rmode)
        0: r = 1'b1;
        1: r = (vc % 2 == 0);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = r;
      if (out_valid) vc++;
      if (out_valid && r) begin
        if (exp_q.size() == 0) begin
          chk("extra_symbol", 1, 0);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          chk("sym_run", 32'(out_run), 32'(e.run));
          chk("sym_val", 32'(out_value), 32'(e.val));
          chk("sym_eob", 32'(out_eob), 32'(e.eob));
          chk("sym_last", 32'(out_last), 32'(e.last));
          got++;
          if (out_last) done = 1;
          if (abort_n > 0 && got == abort_n) return;
        end
      end
      stall = out_valid && !r;
      prev.run  = out_run;
      prev.val  = out_value;
      prev.last = out_last;
    end
    chk("block_done", 32'(done), 1);
    @(negedge clk);
    chk("post_valid", 32'(out_valid), 0);
    chk("post_ready", 32'(in_ready), 1);
    chk("all_symbols", 32'(exp_q.size()), 0);
  endtask

  initial begin
    logic [511:0] b2;
    logic [511:0] b;
    build_zz();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_eob", 32'(out_eob), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_run", 32'(out_run), 0);
    chk("rst_value", 32'(out_value), 0);
    reset = 1'b0;
    @(negedge clk);

    run_block('0, 0, 0, 0);

    b2 = '0;
    b2[0*8 +: 8] = 8'd5;
    b2[1*8 +: 8] = 8'hFD;
    run_block(b2, 0, 0, 0);

    b = '0;
    b[63*8 +: 8] = 8'd7;
    run_block(b, 0, 0, 0);

    run_block(b2, 1, 0, 0);

    b = '0;
    b[0*8 +: 8] = 8'h80;
    b[2*8 +: 8] = 8'd1;
    b[40*8 +: 8] = 8'h7F;
    b[62*8 +: 8] = 8'hFF;
    run_block(b, 1, 0, 2);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_last", 32'(out_last), 0);
    chk("midrst_eob", 32'(out_eob), 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("midrst_idle", 32'(in_ready), 1);
    chk("midrst_quiet", 32'(out_valid), 0);
    run_block(b2, 0, 0, 0);

    run_block(b, 2, 1, 0);
    run_block(b2, 2, 0, 0);

    for (int t = 0; t < 8; t++) begin
      b = '0;
      if (t == 7) begin
        b = {16{$urandom}};
      end else begin
        for (int n = $urandom_range(0, 14); n > 0; n--)
          b[$urandom_range(0, 63)*8 +: 8] = 8'($urandom_range(1, 255));
      end
      run_block(b, 2, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
